// File: rtl/div_unit_seq.sv
// div_unit_seq: iterative restoring divider for the HI/LO path.
// One quotient bit per clock, signed or unsigned operands.
// Quotient goes to Quo (LO) and remainder to Rem (HI).
// Start/Busy/Done handshake with a fixed latency of WIDTH+2 edges.
module div_unit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quo,
    output logic [WIDTH-1:0] Rem,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state;
    logic [WIDTH:0]   rem_acc;       // one spare bit so compare/subtract never overflows
    logic [WIDTH:0]   divisor;
    logic [WIDTH-1:0] quo_acc;       // holds |A| on entry, shifts out into rem_acc
    logic [WIDTH-1:0] dividend_raw;  // original A, returned as Rem on divide-by-zero
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic [CW-1:0]    count;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes, one restoring step, and final sign correction.
    always_comb begin
        a_neg    = Signed & A[WIDTH-1];
        b_neg    = Signed & B[WIDTH-1];
        // For the most-negative value, -A wraps to 2^(WIDTH-1), which is
        // exactly the required magnitude when read as unsigned.
        a_mag    = a_neg ? (~A + 1'b1) : A;
        b_mag    = b_neg ? (~B + 1'b1) : B;

        rem_sh   = {rem_acc, quo_acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, divisor};
        fits     = ~diff[WIDTH+1];
        rem_next = fits ? diff[WIDTH:0] : rem_sh[WIDTH:0];

        q_fix    = neg_q ? (~quo_acc + 1'b1) : quo_acc;
        r_fix    = neg_r ? (~rem_acc[WIDTH-1:0] + 1'b1) : rem_acc[WIDTH-1:0];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= S_IDLE;
            rem_acc      <= '0;
            divisor      <= '0;
            quo_acc      <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            count        <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Quo          <= '0;
            Rem          <= '0;
            DivZero      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        rem_acc      <= '0;
                        divisor      <= {1'b0, b_mag};
                        quo_acc      <= a_mag;
                        dividend_raw <= A;
                        neg_q        <= a_neg ^ b_neg;
                        neg_r        <= a_neg;
                        div_zero     <= (B == '0);
                        count        <= CW'(WIDTH);
                        Busy         <= 1'b1;
                        state        <= S_RUN;
                    end
                end

                S_RUN: begin
                    rem_acc <= rem_next;
                    quo_acc <= {quo_acc[WIDTH-2:0], fits};
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state <= S_FIX;
                    end
                end

                S_FIX: begin
                    // A zero divisor yields all-ones quotient and hands back
                    // the original dividend; sign correction is bypassed.
                    if (div_zero) begin
                        Quo <= '1;
                        Rem <= dividend_raw;
                    end else begin
                        Quo <= q_fix;
                        Rem <= r_fix;
                    end
                    DivZero <= div_zero;
                    Done    <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit_seq.sv
// Scoreboard bench for div_unit_seq: directed corners plus random divides,
// a held-Start handshake sequence and a mid-operation reset.
module tb_div_unit_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sgn = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         divzero;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        int           tag;
    } exp_t;

    exp_t sbq[$];

    div_unit_seq #(.WIDTH(W)) dut (
        .Clk    (clk),
        .Rst    (rst),
        .Start  (start),
        .Signed (sgn),
        .A      (a),
        .B      (b),
        .Busy   (busy),
        .Done   (done),
        .Quo    (quo),
        .Rem    (rem),
        .DivZero(divzero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference divide from plain integer arithmetic.
    function automatic void model(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit dz);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (y == 0) begin
            q  = '1;
            r  = x;
            dz = 1'b1;
        end else if (s) begin
            q  = W'(sx / sy);
            r  = W'(sx % sy);
            dz = 1'b0;
        end else begin
            q  = x / y;
            r  = x % y;
            dz = 1'b0;
        end
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'($urandom_range(1, 9));
            2:       return '1;
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return W'(-$signed(W'($urandom_range(1, 300))));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops expectations on Done and checks values, latency, Busy length, stability.
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;
    logic         last_dz;
    bit           skip = 1'b1;
    int           busy_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (rst) begin
            busy_cnt = 0;
            skip     = 1'b1;
        end else begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done at cycle %0d quo=0x%0h rem=0x%0h", ncyc, quo, rem);
                end else begin
                    e = sbq.pop_front();
                    chk("quo", quo, e.q);
                    chk("rem", rem, e.r);
                    chk("divzero", divzero, e.dz);
                    chk("latency", ncyc, e.tag + W + 2);
                    chk("busy_cycles", busy_cnt, W + 1);
                    chk("busy_at_done", busy, 0);
                end
                busy_cnt = 0;
            end else begin
                if (!skip) begin
                    chk("hold_quo", quo, last_q);
                    chk("hold_rem", rem, last_r);
                    chk("hold_dz", divzero, last_dz);
                end
                if (busy) busy_cnt++;
            end
            skip = 1'b0;
        end
        last_q  = quo;
        last_r  = rem;
        last_dz = divzero;
    end

    task automatic wait_drain();
        for (int i = 0; i < 4 * W; i++) begin
            if (sbq.size() == 0) break;
            @(posedge clk);
        end
        chk("drain", sbq.size(), 0);
        sbq.delete();
        @(posedge clk);
    endtask

    // One divide; optionally fire a stray Start while busy, which must be ignored.
    task automatic issue(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz,
                         input bit inject);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        e.q = eq; e.r = er; e.dz = edz; e.tag = ncyc;
        sbq.push_back(e);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        sgn   = ~s;
        if (inject) begin
            k = $urandom_range(1, W);
            repeat (k - 1) @(posedge clk);
            #1;
            start = 1'b1;
            a     = $urandom;
            b     = $urandom;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_drain();
    endtask

    task automatic issue_model(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input bit inject);
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        model(s, x, y, q, r, dz);
        issue(s, x, y, q, r, dz, inject);
    endtask

    // Start held high with changing operands: only edges 0 and W+2 accept.
    task automatic hold_test();
        exp_t         e;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn   = 1'($urandom);
        a     = rand_op();
        b     = rand_op();
        for (int k = 0; k <= W + 2; k++) begin
            @(posedge clk);
            if (k == 0 || k == W + 2) begin
                model(sgn, a, b, q, r, dz);
                e.q = q; e.r = r; e.dz = dz; e.tag = ncyc;
                sbq.push_back(e);
            end
            #1;
            sgn = 1'($urandom);
            a   = rand_op();
            b   = rand_op();
        end
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quo", quo, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dz", divzero, 0);

        // Directed corners with hand-derived results.
        issue(0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0);
        issue(1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
        issue(1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 0, 1);
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0, 0);
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 1);
        issue(0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, 0);
        issue(1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
        issue(0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 1);
        issue(0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0);
        issue(1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0);

        // Random divides against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            issue_model(1'($urandom), rand_op(), rand_op(), 1'($urandom));
        end

        // Held Start with changing operands.
        hold_test();
        hold_test();

        // Reset at cycle 10 of a divide: abort, no Done, then a fresh divide.
        @(posedge clk);
        #1;
        start = 1'b1;
        sgn   = 1'b0;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quo", quo, 0);
        chk("abort_rem", rem, 0);
        chk("abort_dz", divzero, 0);
        repeat (W + 6) @(posedge clk);
        issue(0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 0);
        issue_model(1, rand_op(), rand_op(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
